// File: rtl/window_gen.sv
`default_nettype none
// ============================================================================
// Module   : window_gen
// Purpose  : Streaming line-buffer front end for conv. Takes a SIZE x SIZE
//            raster pixel stream and emits every SIZEKer x SIZEKer window
//            together with its top-left (i, j) index.
// Revision : 1.0 - initial release
// ============================================================================
module window_gen #(
  parameter int SIZE      = 7,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 8
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [WIDTH_BIT-1:0]                          in_pixel,
  output logic                                          win_valid,
  input  logic                                          win_ready,
  output logic [SIZEKer-1:0][SIZEKer-1:0][WIDTH_BIT-1:0] window,
  output logic [WIDTH_BIT-1:0]                          i,
  output logic [WIDTH_BIT-1:0]                          j,
  output logic                                          frame_done
);

  // Column index width for the line-buffer memories.
  localparam int CIW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [WIDTH_BIT-1:0] KM1  = WIDTH_BIT'(SIZEKer - 1);
  localparam logic [WIDTH_BIT-1:0] LAST = WIDTH_BIT'(SIZE - 1);

  // Position of the next expected pixel.
  logic [WIDTH_BIT-1:0] r_q, r_d;
  logic [WIDTH_BIT-1:0] c_q, c_d;

  // Presented window and its metadata.
  logic                                           valid_q, valid_d;
  logic                                           done_q, done_d;
  logic [WIDTH_BIT-1:0]                           i_q, i_d;
  logic [WIDTH_BIT-1:0]                           j_q, j_d;
  logic [SIZEKer-1:0][SIZEKer-1:0][WIDTH_BIT-1:0] win_q, win_d;

  // Line buffers: row 0 holds the oldest buffered image row.
  logic [WIDTH_BIT-1:0] lb_q [SIZEKer-1][SIZE];

  logic                                accept;
  logic                                emit;
  logic [CIW-1:0]                      col_idx;
  logic [SIZEKer-1:0][WIDTH_BIT-1:0]   col_vec;

  // Handshake decode and the incoming column (buffered rows oldest first, then the new pixel).
  always_comb begin
    in_ready = !(valid_q && !win_ready);
    accept   = in_valid && in_ready;
    emit     = accept && (r_q >= KM1) && (c_q >= KM1);
    col_idx  = c_q[CIW-1:0];
    col_vec  = '0;
    for (int a = 0; a < SIZEKer - 1; a++) begin
      col_vec[a] = lb_q[a][col_idx];
    end
    col_vec[SIZEKer-1] = in_pixel;
  end

  // Next-state for raster counters, window shift register and output metadata.
  always_comb begin
    r_d     = r_q;
    c_d     = c_q;
    win_d   = win_q;
    valid_d = valid_q;
    done_d  = done_q;
    i_d     = i_q;
    j_d     = j_q;

    if (accept) begin
      if (c_q == LAST) begin
        c_d = '0;
        r_d = (r_q == LAST) ? '0 : r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
      // New column enters on the right; leftmost column falls off.
      for (int a = 0; a < SIZEKer; a++) begin
        for (int b = 0; b < SIZEKer - 1; b++) begin
          win_d[a][b] = win_q[a][b+1];
        end
        win_d[a][SIZEKer-1] = col_vec[a];
      end
    end

    if (emit) begin
      valid_d = 1'b1;
      i_d     = r_q - KM1;
      j_d     = c_q - KM1;
      done_d  = (r_q == LAST) && (c_q == LAST);
    end else if (win_ready) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Control and output registers; reset discards any held window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q     <= '0;
      c_q     <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      r_q     <= r_d;
      c_q     <= c_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  // Line-buffer column shift on accept; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int a = 0; a < SIZEKer - 2; a++) begin
        lb_q[a][col_idx] <= lb_q[a+1][col_idx];
      end
      lb_q[SIZEKer-2][col_idx] <= in_pixel;
    end
  end

  assign window     = win_q;
  assign win_valid  = valid_q;
  assign frame_done = done_q;
  assign i          = i_q;
  assign j          = j_q;

endmodule
`default_nettype wire

// File: tb/tb_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_gen
// Purpose  : Randomized self-checking bench for window_gen (7x7 / 3x3 main
//            instance plus a 5x5 / 3x3 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_window_gen;

  localparam int SZ = 7;
  localparam int K  = 3;
  localparam int W  = 8;
  localparam int NW = (SZ - K + 1) * (SZ - K + 1);

  typedef logic [K-1:0][K-1:0][W-1:0] win_t;
  typedef struct {
    int   i;
    int   j;
    bit   done;
    win_t w;
  } exp_t;

  logic         clock     = 1'b0;
  logic         reset     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         win_ready = 1'b1;
  logic [W-1:0] in_pixel  = '0;
  logic         in_ready;
  logic         win_valid;
  win_t         window;
  logic [W-1:0] i, j;
  logic         frame_done;

  logic         s_in_valid  = 1'b0;
  logic         s_win_ready = 1'b1;
  logic [W-1:0] s_in_pixel  = '0;
  logic         s_in_ready;
  logic         s_win_valid;
  win_t         s_window;
  logic [W-1:0] s_i, s_j;
  logic         s_frame_done;

  always #5 clock = ~clock;

  window_gen #(.SIZE(SZ), .SIZEKer(K), .WIDTH_BIT(W)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .win_valid(win_valid), .win_ready(win_ready),
    .window(window), .i(i), .j(j), .frame_done(frame_done)
  );

  window_gen #(.SIZE(5), .SIZEKer(K), .WIDTH_BIT(W)) u_dut5 (
    .clock(clock), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_pixel(s_in_pixel), .win_valid(s_win_valid), .win_ready(s_win_ready),
    .window(s_window), .i(s_i), .j(s_j), .frame_done(s_frame_done)
  );

  int           vectors    = 0;
  int           miscompares = 0;
  logic [W-1:0] pix_q[$];
  exp_t         exp_q[$];
  int           img[SZ][SZ];
  int           k5 = 0;
  bit           first_chk = 1'b0;

  task automatic check(input bit ok, input string name,
                       input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: enqueue a frame's pixels and every window it must produce.
  task automatic push_frame(input int base, input bit rnd);
    exp_t e;
    for (int r = 0; r < SZ; r++) begin
      for (int c = 0; c < SZ; c++) begin
        img[r][c] = rnd ? int'($urandom_range(255)) : ((base + SZ * r + c) & 255);
        pix_q.push_back(W'(img[r][c]));
      end
    end
    for (int ii = 0; ii <= SZ - K; ii++) begin
      for (int jj = 0; jj <= SZ - K; jj++) begin
        e.i    = ii;
        e.j    = jj;
        e.done = (ii == SZ - K) && (jj == SZ - K);
        for (int a = 0; a < K; a++)
          for (int b = 0; b < K; b++)
            e.w[a][b] = W'(img[ii+a][jj+b]);
        exp_q.push_back(e);
      end
    end
  endtask

  // Per-cycle comparison of both instances against the reference.
  task automatic compare_cycle();
    exp_t e;
    win_t sw;
    int   si, sj;
    check(in_ready == !(win_valid && !win_ready), "in_ready",
          128'(in_ready), 128'(!(win_valid && !win_ready)));
    if (win_valid) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "spurious_window", 128'({i, j}), 128'(0));
      end else begin
        e = exp_q[0];
        check(i == W'(e.i) && j == W'(e.j), "index", 128'({i, j}), 128'({W'(e.i), W'(e.j)}));
        check(window == e.w, "window", 128'(window), 128'(e.w));
        check(frame_done == e.done, "frame_done", 128'(frame_done), 128'(e.done));
        if (win_ready) void'(exp_q.pop_front());
      end
    end else begin
      check(frame_done == 1'b0, "frame_done_idle", 128'(frame_done), 128'(0));
    end
    if (s_win_valid) begin
      si = k5 / 3;
      sj = k5 % 3;
      for (int a = 0; a < K; a++)
        for (int b = 0; b < K; b++)
          sw[a][b] = W'(5 * (si + a) + sj + b);
      check(int'(s_i) == si && int'(s_j) == sj && s_window == sw && s_frame_done == (k5 == 8),
            "size5_window", 128'({s_i, s_j, s_frame_done, s_window}),
            128'({W'(si), W'(sj), (k5 == 8), sw}));
      if (k5 == 8)
        check(s_window[2][2] == 8'd24 && s_frame_done, "size5_last",
              128'({s_frame_done, s_window[2][2]}), 128'({1'b1, 8'd24}));
      k5++;
    end
  endtask

  task automatic tick(output bit acc);
    @(negedge clock);
    compare_cycle();
    acc = in_valid && in_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic run_stream(input int valid_pct, input bit ready_rnd, input bit hold_en,
                            input int stop_after, input int max_cycles);
    int sent      = 0;
    int cyc       = 0;
    int hold_left = 0;
    bit hold_done = 1'b0;
    bit acc;
    while ((pix_q.size() > 0 || exp_q.size() > 0) && sent != stop_after) begin
      if (cyc >= max_cycles) begin
        check(1'b0, "timeout", 128'(exp_q.size()), 128'(0));
        pix_q.delete();
        exp_q.delete();
        break;
      end
      if (hold_en && !hold_done && win_valid && i == 8'd1 && j == 8'd2) begin
        hold_left = 5;
        hold_done = 1'b1;
      end
      in_valid  = (pix_q.size() > 0) && ($urandom_range(99) < valid_pct);
      in_pixel  = (pix_q.size() > 0) ? pix_q[0] : '0;
      win_ready = (hold_left > 0) ? 1'b0 : (ready_rnd ? 1'($urandom_range(1)) : 1'b1);
      if (hold_left > 0) begin
        #1;
        check(win_valid && window[0][0] == 8'd9 && i == 8'd1 && j == 8'd2, "hold_window",
              128'({win_valid, i, j, window[0][0]}), 128'({1'b1, 8'd1, 8'd2, 8'd9}));
        check(in_ready == 1'b0, "hold_in_ready", 128'(in_ready), 128'(0));
        hold_left--;
      end
      tick(acc);
      if (acc) begin
        void'(pix_q.pop_front());
        sent++;
        if (first_chk && sent == 17)
          check(win_valid && i == 8'd0 && j == 8'd0 && window[2][2] == 8'd16, "first_latency",
                128'({win_valid, i, j, window[2][2]}), 128'({1'b1, 8'd0, 8'd0, 8'd16}));
      end
      cyc++;
    end
    if (hold_en)
      check(hold_done, "hold_reached", 128'(hold_done), 128'(1));
    in_valid  = 1'b0;
    win_ready = 1'b1;
  endtask

  initial begin
    exp_t e;
    bit   acc;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check(!win_valid && !frame_done && i == 0 && j == 0 && window == '0, "reset_outputs",
          128'({win_valid, frame_done, i, j, window}), 128'(0));
    reset = 1'b0;
    #1;
    check(in_ready == 1'b1, "reset_in_ready", 128'(in_ready), 128'(1));

    // Continuous stream, plus literal pins on the reference
    push_frame(0, 1'b0);
    check(pix_q.size() == 49 && exp_q.size() == NW, "model_sizes",
          128'({pix_q.size(), exp_q.size()}), 128'({32'd49, 32'(NW)}));
    e = exp_q[0];
    check(e.i == 0 && e.j == 0 && e.w[0][0] == 0 && e.w[1][1] == 8 && e.w[2][2] == 16 && !e.done,
          "model_first", 128'(e.w), 128'(0));
    e = exp_q[NW-1];
    check(e.i == 4 && e.j == 4 && e.w[2][2] == 48 && e.done, "model_last",
          128'({e.done, e.w[2][2]}), 128'({1'b1, 8'd48}));
    first_chk = 1'b1;
    run_stream(100, 1'b0, 1'b0, -1, 200);
    first_chk = 1'b0;

    // Backpressure at window (1, 2)
    push_frame(0, 1'b0);
    run_stream(100, 1'b0, 1'b1, -1, 200);

    // Random input gaps and random downstream stalls
    push_frame(0, 1'b0);
    run_stream(50, 1'b1, 1'b0, -1, 1000);
    for (int n = 0; n < 3; n++) begin
      push_frame(0, 1'b1);
      run_stream(60, 1'b1, 1'b0, -1, 1000);
    end

    // Two frames back-to-back
    push_frame(0, 1'b0);
    push_frame(100, 1'b0);
    e = exp_q[NW];
    check(e.i == 0 && e.j == 0 && e.w[0][0] == 100, "model_frame2",
          128'(e.w[0][0]), 128'(100));
    run_stream(100, 1'b0, 1'b0, -1, 300);

    // Reset mid-frame after 20 pixels
    push_frame(0, 1'b0);
    run_stream(100, 1'b0, 1'b0, 20, 200);
    check(win_valid == 1'b1, "pre_reset_window", 128'(win_valid), 128'(1));
    #2 reset = 1'b1;
    #1;
    check(!win_valid && !frame_done && i == 0 && j == 0 && window == '0, "async_reset_outputs",
          128'({win_valid, frame_done, i, j, window}), 128'(0));
    check(in_ready == 1'b1, "async_reset_in_ready", 128'(in_ready), 128'(1));
    pix_q.delete();
    exp_q.delete();
    tick(acc);
    tick(acc);
    reset = 1'b0;
    push_frame(0, 1'b0);
    run_stream(100, 1'b0, 1'b0, -1, 200);

    // 5x5 instance, continuous stream
    for (int p = 0; p < 25; p++) begin
      s_in_valid = 1'b1;
      s_in_pixel = W'(p);
      tick(acc);
    end
    s_in_valid = 1'b0;
    repeat (3) tick(acc);
    check(k5 == 9, "size5_count", 128'(k5), 128'(9));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/window_gen.md
# window_gen

Streaming sliding-window generator sitting directly upstream of `conv`. Accepts a SIZE×SIZE image as a raster-scan pixel stream (row-major, one pixel per handshake), buffers SIZEKer-1 full rows plus a SIZEKer-wide shift window, and emits every valid SIZEKer×SIZEKer window in the layout `conv` expects on `inpMatrixI`. It also emits the window's top-left (i, j) index for placement into the (SIZE-SIZEKer+1)² output map. Together these replace software slicing of a stored matrix with a hardware line-buffer front end.

## Interface
Parameters:
- SIZE, 7, image width and height in pixels; must satisfy SIZE >= SIZEKer and SIZE <= 2**WIDTH_BIT
- SIZEKer, 3, kernel/window edge length; must be >= 2
- WIDTH_BIT, 8, pixel width and index width

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all control state immediately
- in_valid  in  1  in_pixel is valid
- in_ready  out  1  block can accept a pixel this cycle (combinational)
- in_pixel  in  WIDTH_BIT  next pixel in raster order
- win_valid  out  1  window/index outputs valid
- win_ready  in  1  downstream accepts the current window
- window  out  [WIDTH_BIT-1:0] [SIZEKer-1:0][SIZEKer-1:0]  window[a][b] = I[i+a][j+b]
- i  out  WIDTH_BIT  window top-left row, 0..SIZE-SIZEKer
- j  out  WIDTH_BIT  window top-left column, 0..SIZE-SIZEKer
- frame_done  out  1  high together with win_valid on the last window of a frame (i = j = SIZE-SIZEKer)

## Operation
- Accept: a pixel is taken when in_valid && in_ready.
- in_ready = !(win_valid && !win_ready).
- Counters: row r and column c of the next expected pixel. On accept: c increments; at c = SIZE-1, c wraps to 0 and r increments; at (SIZE-1, SIZE-1), both wrap to 0. Back-to-back frames need no idle cycle.
- Line buffers: SIZEKer-1 row memories of SIZE entries, indexed by c. On accept, column c of each line buffer shifts up one row and the new pixel enters the bottom row. The column vector (line buffer rows oldest→newest, then in_pixel) shifts into the SIZEKer×SIZEKer window register from the right.
- Emission: an accept at (r, c) with r >= SIZEKer-1 and c >= SIZEKer-1 registers a window. On the next edge, win_valid=1, i=r-SIZEKer+1, j=c-SIZEKer+1, and frame_done=(r==SIZE-1 && c==SIZE-1).
- Accepts in columns < SIZEKer-1 or rows < SIZEKer-1 update the buffers only. Stale columns from the previous row or frame are never exposed.
- Hold: while win_valid && !win_ready, window, i, j, win_valid and frame_done are held stable and no pixel is accepted.
- Release: if win_ready=1 and no new window is registered, win_valid and frame_done drop on the next edge.
- Windows per frame: exactly (SIZE-SIZEKer+1)², in raster order of (i, j).
- Arithmetic: unsigned counters, WIDTH_BIT wide. No data arithmetic; pixels pass through bit-exact.

## Timing
- Reset values: win_valid=0, frame_done=0, i=0, j=0, window all zeros, r=c=0. in_ready reads 1 while reset is released and win_valid=0.
- Line buffer contents are not cleared by reset.
- Latency: accept of pixel (r, c) to the corresponding window on outputs is 1 cycle.
- Throughput: 1 pixel/cycle and up to 1 window/cycle with win_ready held high.
- Simultaneous events: win_ready=1 with an accept in the same cycle replaces the window on the next edge. win_valid stays high with no bubble.
- Reset mid-frame: takes effect asynchronously. Any held window is discarded. The next accepted pixel is treated as (0, 0) of a new frame.
- in_valid low: counters and window hold. The window currently presented stays valid until consumed.

## Test plan
- Continuous 7×7 stream, I[r][c]=7r+c, in_valid=1, win_ready=1 -> 25 windows on consecutive output cycles within each row, with row gaps of 2 cycles.
  - First window: one cycle after pixel 16 is accepted; i=0, j=0, window[0][0]=0, window[1][1]=8, window[2][2]=16.
  - Last window: i=4, j=4, window[2][2]=48, frame_done=1.
- Backpressure: hold win_ready=0 for 5 cycles at window (1, 2) -> window[0][0]=9 stays stable, in_ready=0, no pixel lost. After release, the remaining windows match the first test exactly.
- Random in_valid gaps (about 50% duty) on the same image -> identical window/i/j sequence; win_valid never asserts without a new window.
- Two frames back-to-back, second frame I[r][c]=100+7r+c -> first window of frame 2 has window[0][0]=100, i=j=0. No window mixes frames.
- Assert reset after 20 pixels, then stream a full frame -> all outputs return to reset values immediately. The following 25 windows match the first test.
- SIZE=5, SIZEKer=3 build -> 9 windows; frame_done on (2, 2) with window[2][2]=24.
